// File: rtl/axis_mem_packer.sv
// -----------------------------------------------------------------------------
// axis_mem_packer
//
// Repacks an AXI-stream packet into fixed-size memory words. Each packet is
// written out as one header word (the first-beat tuser, zero-extended),
// followed by data words of OUT_BYTES bytes. The last data word carries the
// remaining byte count and eop. Bytes are staged in a residue buffer of
// IN_BYTES+OUT_BYTES bytes. Byte 0 of that buffer is always the oldest byte.
//
// Ports
//   clk            single clock
//   reset          synchronous, active-high reset
//   s_axis_*       slave stream: tvalid/tready/tlast, tdata (byte 0 in LSBs),
//                  tstrb (contiguous byte enables), tuser (first beat only)
//   dout           {payload[8*OUT_BYTES], byte_count[CNT_W], sop, eop}
//   dout_valid     word valid, held until dout_ready
//   dout_ready     downstream ready
//   oq             one-hot destination queue of the current packet
//   err_strb       one-cycle pulse on a protocol error
//
// Optional feature macro: AXIS_MEM_PACKER_PKT_CNT_EN
//   When defined, this macro adds two outputs:
//   pkt_cnt    eop words transferred
//   byte_cnt   payload bytes of transferred data words
//   Both counters are 32 bits wide and wrap.
// -----------------------------------------------------------------------------
module axis_mem_packer #(
   parameter int IN_BYTES    = 32,
   parameter int OUT_BYTES   = 24,
   parameter int TUSER_WIDTH = 128,
   parameter int NUM_QUEUES  = 5,
   parameter int QUEUE_LSB   = 24,
   localparam int CNT_W      = $clog2(OUT_BYTES + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic [8*IN_BYTES-1:0]          s_axis_tdata,
   input  logic [IN_BYTES-1:0]            s_axis_tstrb,
   input  logic [TUSER_WIDTH-1:0]         s_axis_tuser,
   output logic [8*OUT_BYTES+CNT_W+1:0]   dout,
   output logic                           dout_valid,
   input  logic                           dout_ready,
   output logic [NUM_QUEUES-1:0]          oq,
   output logic                           err_strb
`ifdef AXIS_MEM_PACKER_PKT_CNT_EN
   ,
   output logic [31:0]                    pkt_cnt,
   output logic [31:0]                    byte_cnt
`endif
);

   localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
   localparam int BUF_W     = 8 * BUF_BYTES;
   localparam int PAY_W     = 8 * OUT_BYTES;
   localparam int DOUT_W    = PAY_W + CNT_W + 2;
   localparam int FILL_W    = $clog2(BUF_BYTES + 1);
   localparam int SUM_W     = FILL_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HDR   = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_BYTES);

   // Number of enabled bytes in a strobe.
   function automatic logic [FILL_W-1:0] popcount_f(input logic [IN_BYTES-1:0] v);
      logic [FILL_W-1:0] n;
      n = '0;
      for (int i = 0; i < IN_BYTES; i++) n = n + FILL_W'(v[i]);
      return n;
   endfunction

   // True when the set strobe bits run unbroken from bit 0.
   function automatic logic contiguous_f(input logic [IN_BYTES-1:0] v);
      return ((v & (v + IN_BYTES'(1))) == '0);
   endfunction

   // True when exactly one bit is set.
   function automatic logic onehot_f(input logic [NUM_QUEUES-1:0] v);
      return (v != '0) && ((v & (v - NUM_QUEUES'(1))) == '0);
   endfunction

   // Byte mask that keeps the lowest n bytes of a beat.
   function automatic logic [8*IN_BYTES-1:0] byte_mask_f(input logic [FILL_W-1:0] n);
      logic [8*IN_BYTES-1:0] m;
      for (int i = 0; i < IN_BYTES; i++) m[8*i +: 8] = (FILL_W'(i) < n) ? 8'hFF : 8'h00;
      return m;
   endfunction

   logic [1:0]             state_r, state_n;
   logic [FILL_W-1:0]      fill_r, fill_n;
   logic [BUF_W-1:0]       buf_r, buf_n;
   logic                   last_seen_r, last_seen_n;
   logic [DOUT_W-1:0]      dout_r, dout_n;
   logic                   dout_valid_r, dout_valid_n;
   logic [NUM_QUEUES-1:0]  oq_r, oq_n;
   logic                   err_r, err_n;

   logic                   out_free_s;
   logic                   xfer_s;
   logic                   emit_s;
   logic                   tready_s;
   logic                   accept_s;
   logic                   strb_err_s;
   logic [FILL_W-1:0]      nbytes_s;
   logic [FILL_W-1:0]      fill_after_s;
   logic [BUF_W-1:0]       beat_s;
   logic [BUF_W-1:0]       shifted_s;

   // Next-state logic: acceptance, residue buffer update and word emission.
   always_comb begin
      state_n      = state_r;
      fill_n       = fill_r;
      buf_n        = buf_r;
      last_seen_n  = last_seen_r;
      dout_n       = dout_r;
      dout_valid_n = dout_valid_r && !dout_ready;
      oq_n         = oq_r;
      err_n        = 1'b0;
      emit_s       = 1'b0;
      tready_s     = 1'b0;
      fill_after_s = fill_r;
      shifted_s    = buf_r;

      // The output register can take a new word when it is empty or draining now.
      out_free_s = !dout_valid_r || dout_ready;
      xfer_s     = dout_valid_r && dout_ready;
      nbytes_s   = popcount_f(s_axis_tstrb);
      // Bytes beyond the counted ones are zeroed, so everything above fill stays zero.
      beat_s     = BUF_W'(s_axis_tdata & byte_mask_f(nbytes_s));
      strb_err_s = (!s_axis_tlast && (s_axis_tstrb != {IN_BYTES{1'b1}})) ||
                   !contiguous_f(s_axis_tstrb);

      case (state_r)
         S_IDLE: begin
            tready_s = (fill_r == '0) && out_free_s;
            if (s_axis_tvalid && tready_s && !reset) begin
               oq_n         = s_axis_tuser[QUEUE_LSB +: NUM_QUEUES];
               buf_n        = beat_s;
               fill_n       = nbytes_s;
               last_seen_n  = s_axis_tlast;
               dout_n       = {PAY_W'(s_axis_tuser), CNT_W'(OUT_BYTES), 1'b1, 1'b0};
               dout_valid_n = 1'b1;
               err_n        = strb_err_s || !onehot_f(s_axis_tuser[QUEUE_LSB +: NUM_QUEUES]);
               state_n      = S_HDR;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_HDR: begin
            if (xfer_s) begin
               state_n = last_seen_r ? S_FLUSH : S_DATA;
            end else begin
               state_n = S_HDR;
            end
         end
         S_DATA: begin
            emit_s = (fill_r >= OUT_FILL) && out_free_s;
            if (emit_s) begin
               fill_after_s = fill_r - OUT_FILL;
               shifted_s    = buf_r >> PAY_W;
               dout_n       = {buf_r[PAY_W-1:0], CNT_W'(OUT_BYTES), 1'b0, 1'b0};
               dout_valid_n = 1'b1;
            end else begin
               fill_after_s = fill_r;
               shifted_s    = buf_r;
            end
            // Accept a beat only if it fits on top of what remains after this emit.
            tready_s = !last_seen_r &&
                       (({1'b0, fill_after_s} + SUM_W'(IN_BYTES)) <= SUM_W'(BUF_BYTES));
            buf_n  = shifted_s;
            fill_n = fill_after_s;
            if (s_axis_tvalid && tready_s && !reset) begin
               buf_n  = shifted_s | (beat_s << {fill_after_s, 3'b000});
               fill_n = fill_after_s + nbytes_s;
               err_n  = strb_err_s;
               if (s_axis_tlast) begin
                  last_seen_n = 1'b1;
                  state_n     = S_FLUSH;
               end else begin
                  state_n = S_DATA;
               end
            end else begin
               state_n = S_DATA;
            end
         end
         S_FLUSH: begin
            if (out_free_s) begin
               if (fill_r <= OUT_FILL) begin
                  // Final word: the remaining bytes, zero above them, plus eop.
                  dout_n       = {buf_r[PAY_W-1:0], CNT_W'(fill_r), 1'b0, 1'b1};
                  dout_valid_n = 1'b1;
                  buf_n        = '0;
                  fill_n       = '0;
                  last_seen_n  = 1'b0;
                  state_n      = S_IDLE;
               end else begin
                  dout_n       = {buf_r[PAY_W-1:0], CNT_W'(OUT_BYTES), 1'b0, 1'b0};
                  dout_valid_n = 1'b1;
                  buf_n        = buf_r >> PAY_W;
                  fill_n       = fill_r - OUT_FILL;
                  state_n      = S_FLUSH;
               end
            end else begin
               state_n = S_FLUSH;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      accept_s = s_axis_tvalid && tready_s;
   end

   // State and output registers; reset discards any buffered bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         fill_r       <= '0;
         buf_r        <= '0;
         last_seen_r  <= 1'b0;
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
         oq_r         <= '0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_n;
         fill_r       <= fill_n;
         buf_r        <= buf_n;
         last_seen_r  <= last_seen_n;
         dout_r       <= dout_n;
         dout_valid_r <= dout_valid_n;
         oq_r         <= oq_n;
         err_r        <= err_n;
      end
   end

`ifdef AXIS_MEM_PACKER_PKT_CNT_EN
   logic [31:0] pkt_cnt_r;
   logic [31:0] byte_cnt_r;

   // Packet and byte counters. Headers (sop=1) add no bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_r  <= 32'd0;
         byte_cnt_r <= 32'd0;
      end else if (xfer_s) begin
         pkt_cnt_r  <= dout_r[0] ? pkt_cnt_r + 32'd1 : pkt_cnt_r;
         byte_cnt_r <= dout_r[1] ? byte_cnt_r : byte_cnt_r + 32'(dout_r[CNT_W+1:2]);
      end else begin
         pkt_cnt_r  <= pkt_cnt_r;
         byte_cnt_r <= byte_cnt_r;
      end
   end

   assign pkt_cnt  = pkt_cnt_r;
   assign byte_cnt = byte_cnt_r;
`endif

   assign s_axis_tready = tready_s && !reset;
   assign dout          = dout_r;
   assign dout_valid    = dout_valid_r;
   assign oq            = oq_r;
   assign err_strb      = err_r;

endmodule

// File: tb/tb_axis_mem_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_mem_packer
//
// Directed bench for axis_mem_packer at its default parameters. Packet byte k
// carries (seed + k). Bytes outside the strobe are driven as 0xEE.
// Transferred words are collected at the negative edge and compared with
// hand-derived word counts, control fields and payloads.
// -----------------------------------------------------------------------------
module tb_axis_mem_packer;

   localparam int CNT_W  = 5;
   localparam int PAY_W  = 192;
   localparam int DOUT_W = PAY_W + CNT_W + 2;

   localparam logic [127:0] USER_A = {96'h123456789ABCDEF013579BDF, 32'h0400ABCD};
   localparam logic [127:0] USER_B = {96'h0, 32'h01001111};
   localparam logic [127:0] USER_C = {96'hFEDCBA, 32'h10004444};
   localparam logic [127:0] USER_D = {96'h0, 32'h03002222};
   localparam logic [127:0] USER_E = {96'h0, 32'h02003333};

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 s_axis_tvalid;
   logic                 s_axis_tready;
   logic                 s_axis_tlast;
   logic [255:0]         s_axis_tdata;
   logic [31:0]          s_axis_tstrb;
   logic [127:0]         s_axis_tuser;
   logic [DOUT_W-1:0]    dout;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [4:0]           oq;
   logic                 err_strb;
`ifdef AXIS_MEM_PACKER_PKT_CNT_EN
   logic [31:0]          pkt_cnt;
   logic [31:0]          byte_cnt;
`endif

   axis_mem_packer dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .oq            (oq),
      .err_strb      (err_strb)
`ifdef AXIS_MEM_PACKER_PKT_CNT_EN
      ,
      .pkt_cnt       (pkt_cnt),
      .byte_cnt      (byte_cnt)
`endif
   );

   always #5 clk = ~clk;

   int                cmp_cnt  = 0;
   int                miss_cnt = 0;
   int                err_seen = 0;
   int                err_base;
   logic [DOUT_W-1:0] words_q[$];
   logic [DOUT_W-1:0] held;

   // Word and error-pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && dout_valid && dout_ready) words_q.push_back(dout);
      if (err_strb) err_seen <= err_seen + 1;
   end

   task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] make_data(input int seed, input int off, input int nb);
      logic [255:0] d;
      for (int b = 0; b < 32; b++) d[8*b +: 8] = (b < nb) ? 8'(seed + off + b) : 8'hEE;
      return d;
   endfunction

   function automatic logic [PAY_W-1:0] exp_payload(input int seed, input int off, input int cnt);
      logic [PAY_W-1:0] p;
      for (int i = 0; i < 24; i++) p[8*i +: 8] = (i < cnt) ? 8'(seed + off + i) : 8'h00;
      return p;
   endfunction

   task automatic send_beat(input logic [255:0] data, input logic [31:0] strb,
                            input logic last, input logic [127:0] user);
      logic ok;
      ok            = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data;
      s_axis_tstrb  = strb;
      s_axis_tlast  = last;
      s_axis_tuser  = user;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            ok = 1'b1;
            break;
         end
      end
      check_value("beat_accept", 256'(ok), 256'(1'b1));
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_packet(input int seed, input int total, input logic [127:0] user);
      int nb;
      for (int off = 0; off < total; off += nb) begin
         nb = (total - off > 32) ? 32 : total - off;
         send_beat(make_data(seed, off, nb),
                   (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1),
                   (off + nb >= total), user);
      end
   endtask

   task automatic check_packet(input string tag, input logic [127:0] user, input int seed,
                               input int total, input int nwords);
      logic [DOUT_W-1:0] w;
      int                cnt_e;
      for (int i = 0; i < 300 && words_q.size() < nwords; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check_value({tag, "_nwords"}, 256'(words_q.size()), 256'(nwords));
      for (int j = 0; j < nwords && words_q.size() > 0; j++) begin
         w = words_q.pop_front();
         if (j == 0) begin
            check_value({tag, "_hdr_ctl"}, 256'(w[CNT_W+1:0]), 256'({5'd24, 1'b1, 1'b0}));
            check_value({tag, "_hdr_pay"}, 256'(w[DOUT_W-1 -: PAY_W]), 256'({64'h0, user}));
         end else begin
            cnt_e = total - 24 * (j - 1);
            if (cnt_e > 24) cnt_e = 24;
            check_value($sformatf("%s_w%0d_ctl", tag, j), 256'(w[CNT_W+1:0]),
                        256'({5'(cnt_e), 1'b0, (j == nwords - 1)}));
            check_value($sformatf("%s_w%0d_pay", tag, j), 256'(w[DOUT_W-1 -: PAY_W]),
                        256'(exp_payload(seed, 24 * (j - 1), cnt_e)));
         end
      end
      words_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      words_q.delete();
   endtask

   initial begin
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
      dout_ready    = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_tready", 256'(s_axis_tready), 256'(1'b0));
      check_value("rst_dvalid", 256'(dout_valid), 256'(1'b0));
      check_value("rst_dout", 256'(dout), 256'(0));
      check_value("rst_oq", 256'(oq), 256'(5'b00000));
      check_value("rst_err", 256'(err_strb), 256'(1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_value("post_rst_tready", 256'(s_axis_tready), 256'(1'b1));
      @(posedge clk);
      #1;

      // 64-byte packet to queue 2: header, 24, 24, 16+eop
      err_base = err_seen;
      send_beat(make_data(8'h10, 0, 32), 32'hFFFF_FFFF, 1'b0, USER_A);
      check_value("t1_hdr_latency", 256'(dout_valid), 256'(1'b1));
      check_value("t1_hdr_tready", 256'(s_axis_tready), 256'(1'b0));
      send_beat(make_data(8'h10, 32, 32), 32'hFFFF_FFFF, 1'b1, USER_A);
      check_packet("t1", USER_A, 8'h10, 64, 4);
      check_value("t1_oq", 256'(oq), 256'(5'b00100));
      check_value("t1_err", 256'(err_seen - err_base), 256'(0));

      // 48-byte packet: exact multiple, eop on the second 24-byte word
      send_beat(make_data(8'h40, 0, 32), 32'hFFFF_FFFF, 1'b0, USER_B);
      send_beat(make_data(8'h40, 32, 16), 32'h0000_FFFF, 1'b1, USER_B);
      check_packet("t2", USER_B, 8'h40, 48, 3);
      check_value("t2_oq", 256'(oq), 256'(5'b00001));

      // Backpressure: 96-byte packet, output stalled for 5 cycles with 40 bytes held
      send_beat(make_data(8'h70, 0, 32), 32'hFFFF_FFFF, 1'b0, USER_A);
      send_beat(make_data(8'h70, 32, 32), 32'hFFFF_FFFF, 1'b0, USER_A);
      dout_ready = 1'b0;
      held       = dout;
      fork
         send_beat(make_data(8'h70, 64, 32), 32'hFFFF_FFFF, 1'b1, USER_A);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check_value("t3_dout_hold", 256'(dout), 256'(held));
               check_value("t3_dvalid_hold", 256'(dout_valid), 256'(1'b1));
               check_value("t3_tready_full", 256'(s_axis_tready), 256'(1'b0));
            end
            @(posedge clk);
            #1;
            dout_ready = 1'b1;
         end
      join
      check_packet("t3", USER_A, 8'h70, 96, 5);

      // Short non-last beat: error pulse, 16 + 32 bytes still forwarded
      err_base = err_seen;
      send_beat(make_data(8'h90, 0, 16), 32'h0000_FFFF, 1'b0, USER_C);
      send_beat(make_data(8'h90, 16, 32), 32'hFFFF_FFFF, 1'b1, USER_C);
      check_packet("t4", USER_C, 8'h90, 48, 3);
      check_value("t4_err", 256'(err_seen - err_base), 256'(1));
      check_value("t4_oq", 256'(oq), 256'(5'b10000));

      // Destination not one-hot, 1-byte packet: error pulse, still forwarded
      err_base = err_seen;
      send_beat(make_data(8'hA0, 0, 1), 32'h0000_0001, 1'b1, USER_D);
      check_packet("t4b", USER_D, 8'hA0, 1, 2);
      check_value("t4b_err", 256'(err_seen - err_base), 256'(1));
      check_value("t4b_oq", 256'(oq), 256'(5'b00011));

      // Empty tlast beat: header then a count-0 eop word
      err_base = err_seen;
      send_beat(make_data(8'hB0, 0, 0), 32'h0000_0000, 1'b1, USER_E);
      check_packet("t4c", USER_E, 8'hB0, 0, 2);
      check_value("t4c_err", 256'(err_seen - err_base), 256'(0));

      // Reset after beat 2 of a 4-beat packet, then a clean 32-byte packet
      send_beat(make_data(8'hC0, 0, 32), 32'hFFFF_FFFF, 1'b0, USER_A);
      send_beat(make_data(8'hC0, 32, 32), 32'hFFFF_FFFF, 1'b0, USER_A);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_value("t5_dvalid", 256'(dout_valid), 256'(1'b0));
      check_value("t5_oq", 256'(oq), 256'(5'b00000));
      check_value("t5_tready_rst", 256'(s_axis_tready), 256'(1'b0));
      reset = 1'b0;
      @(negedge clk);
      check_value("t5_tready_post", 256'(s_axis_tready), 256'(1'b1));
      @(posedge clk);
      #1;
      words_q.delete();
      send_beat(make_data(8'hD0, 0, 32), 32'hFFFF_FFFF, 1'b1, USER_B);
      check_packet("t5", USER_B, 8'hD0, 32, 3);

      // Three packets of 64, 48 and 1 bytes from a fresh reset
      do_reset();
      send_packet(8'h11, 64, USER_A);
      check_packet("t6a", USER_A, 8'h11, 64, 4);
      send_packet(8'h22, 48, USER_B);
      check_packet("t6b", USER_B, 8'h22, 48, 3);
      send_packet(8'h33, 1, USER_C);
      check_packet("t6c", USER_C, 8'h33, 1, 2);
`ifdef AXIS_MEM_PACKER_PKT_CNT_EN
      check_value("t6_pkt_cnt", 256'(pkt_cnt), 256'(32'd3));
      check_value("t6_byte_cnt", 256'(byte_cnt), 256'(32'd113));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, miss_cnt);
      $finish;
   end

endmodule
